quant_int8_nch: RTL and testbench

- Parametrised per-channel requantiser. Converts CH_NUM signed accumulator lanes to uint8 using scale = mult / 2^shift, round-half-up, zero-point add and saturation.
- Sits between the conv/accumulate array and the feature-map write buffer.
- Generalises the fixed 8-lane, shared-parameter quantiser with:
  - configurable lane count and input width;
  - per-channel mult/shift/zero_point table loaded through a config port;
  - valid/ready backpressure.

---
 rtl/quant_int8_nch.sv | 154 +++++++++++++++
 tb/tb_quant_int8_nch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/quant_int8_nch.sv
// rtl/quant_int8_nch.sv - per-channel int8 requantiser: mult/shift scale, round, zero point, saturate.
// Optional macro QUANT_RELU_EN: lower clamp becomes the lane zero point (fused ReLU).
module quant_int8_nch #(
  parameter int  CH_NUM  = 8,
  parameter int  DIN_W   = 24,
  parameter int  MULT_W  = 15,
  parameter int  SHIFT_W = 6,
  localparam int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                    sclk,
  input  logic                    s_rst,
  input  logic [CH_NUM*DIN_W-1:0] data_in,
  input  logic                    data_in_vld,
  output logic                    data_in_rdy,
  input  logic                    cfg_wr,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [MULT_W-1:0]       cfg_mult,
  input  logic [SHIFT_W-1:0]      cfg_shift,
  input  logic [7:0]              cfg_zp,
  output logic [CH_NUM*8-1:0]     data_out,
  output logic                    data_out_vld,
  input  logic                    data_out_rdy
);

  localparam int PROD_W = DIN_W + MULT_W + 1;
  localparam int SUM_W  = PROD_W + 1;
  localparam int MAX_SH = DIN_W + MULT_W;
  localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'(255);

  logic [MULT_W-1:0]  mult_q  [CH_NUM];
  logic [SHIFT_W-1:0] shift_q [CH_NUM];
  logic [7:0]         zp_q    [CH_NUM];

  logic v1_q, v2_q, v3_q, v4_q, v5_q;
  logic en;

  logic signed [DIN_W-1:0]  d1_q   [CH_NUM];
  logic [MULT_W-1:0]        m1_q   [CH_NUM];
  logic [SHIFT_W-1:0]       s1_q   [CH_NUM];
  logic [7:0]               z1_q   [CH_NUM];
  logic signed [PROD_W-1:0] p2_q   [CH_NUM];
  logic [SHIFT_W-1:0]       s2_q   [CH_NUM];
  logic [7:0]               z2_q   [CH_NUM];
  logic signed [PROD_W-1:0] sh3_q  [CH_NUM];
  logic [7:0]               z3_q   [CH_NUM];
  logic signed [SUM_W-1:0]  sum4_q [CH_NUM];
`ifdef QUANT_RELU_EN
  logic [7:0]               z4_q   [CH_NUM];
`endif
  logic [CH_NUM*8-1:0]      out_q;

  logic signed [PROD_W-1:0] p_d   [CH_NUM];
  logic signed [PROD_W-1:0] sh_d  [CH_NUM];
  logic signed [SUM_W-1:0]  sum_d [CH_NUM];
  logic [7:0]               sat_d [CH_NUM];

  // Whole pipeline advances together; it only freezes while an output beat is refused.
  assign en           = ~v5_q | data_out_rdy;
  assign data_in_rdy  = en;
  assign data_out_vld = v5_q;
  assign data_out     = out_q;

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      for (int k = 0; k < CH_NUM; k++) begin
        mult_q[k]  <= '0;
        shift_q[k] <= '0;
        zp_q[k]    <= '0;
      end
    end else if (cfg_wr && (32'(cfg_ch) < CH_NUM)) begin
      mult_q[cfg_ch]  <= cfg_mult;
      shift_q[cfg_ch] <= cfg_shift;
      zp_q[cfg_ch]    <= cfg_zp;
    end
  end

  always_comb begin
    int shamt;
    logic signed [PROD_W-1:0] rnd;
    logic signed [SUM_W-1:0]  lo;
    shamt = 0;
    rnd   = '0;
    lo    = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      p_d[k] = PROD_W'(d1_q[k]) * PROD_W'($signed({1'b0, m1_q[k]}));

      shamt = (int'(s2_q[k]) > MAX_SH) ? MAX_SH : int'(s2_q[k]);
      rnd   = '0;
      if (shamt > 0) rnd[shamt-1] = 1'b1;
      sh_d[k] = (p2_q[k] + rnd) >>> shamt;

      sum_d[k] = SUM_W'(sh3_q[k]) + SUM_W'($signed({1'b0, z3_q[k]}));

`ifdef QUANT_RELU_EN
      lo = SUM_W'($signed({1'b0, z4_q[k]}));
`else
      lo = '0;
`endif
      if (sum4_q[k] > MAX_V)   sat_d[k] = 8'hFF;
      else if (sum4_q[k] < lo) sat_d[k] = lo[7:0];
      else                     sat_d[k] = sum4_q[k][7:0];
    end
  end

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      v4_q  <= 1'b0;
      v5_q  <= 1'b0;
      out_q <= '0;
      for (int k = 0; k < CH_NUM; k++) begin
        d1_q[k]   <= '0;
        m1_q[k]   <= '0;
        s1_q[k]   <= '0;
        z1_q[k]   <= '0;
        p2_q[k]   <= '0;
        s2_q[k]   <= '0;
        z2_q[k]   <= '0;
        sh3_q[k]  <= '0;
        z3_q[k]   <= '0;
        sum4_q[k] <= '0;
`ifdef QUANT_RELU_EN
        z4_q[k]   <= '0;
`endif
      end
    end else if (en) begin
      v1_q <= data_in_vld;
      v2_q <= v1_q;
      v3_q <= v2_q;
      v4_q <= v3_q;
      v5_q <= v4_q;
      for (int k = 0; k < CH_NUM; k++) begin
        // Parameters are snapshotted here so later table writes never touch in-flight beats.
        d1_q[k]   <= data_in[k*DIN_W +: DIN_W];
        m1_q[k]   <= mult_q[k];
        s1_q[k]   <= shift_q[k];
        z1_q[k]   <= zp_q[k];
        p2_q[k]   <= p_d[k];
        s2_q[k]   <= s1_q[k];
        z2_q[k]   <= z1_q[k];
        sh3_q[k]  <= sh_d[k];
        z3_q[k]   <= z2_q[k];
        sum4_q[k] <= sum_d[k];
`ifdef QUANT_RELU_EN
        z4_q[k]   <= z3_q[k];
`endif
        if (v4_q) out_q[k*8 +: 8] <= sat_d[k];
      end
    end
  end

endmodule

// File: tb/tb_quant_int8_nch.sv
// tb/tb_quant_int8_nch.sv - directed-vector bench for quant_int8_nch (default 8 lanes x 24 bits).
module tb_quant_int8_nch;
  localparam int CH = 8;
  localparam int DW = 24;
`ifdef QUANT_RELU_EN
  localparam logic [7:0] EXP_M101 = 8'd128;
`else
  localparam logic [7:0] EXP_M101 = 8'd78;
`endif

  logic            sclk = 1'b0;
  logic            s_rst;
  logic [CH*DW-1:0] data_in;
  logic            data_in_vld;
  logic            data_in_rdy;
  logic            cfg_wr;
  logic [2:0]      cfg_ch;
  logic [14:0]     cfg_mult;
  logic [5:0]      cfg_shift;
  logic [7:0]      cfg_zp;
  logic [CH*8-1:0] data_out;
  logic            data_out_vld;
  logic            data_out_rdy;

  int n_vec = 0;
  int n_err = 0;

  quant_int8_nch dut (
    .sclk(sclk), .s_rst(s_rst),
    .data_in(data_in), .data_in_vld(data_in_vld), .data_in_rdy(data_in_rdy),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp),
    .data_out(data_out), .data_out_vld(data_out_vld), .data_out_rdy(data_out_rdy)
  );

  always #5 sclk = ~sclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_lanes(input logic signed [DW-1:0] v);
    for (int k = 0; k < CH; k++) data_in[k*DW +: DW] = v;
  endtask

  task automatic cfg(input int ch, input int m, input int s, input int z);
    cfg_wr = 1'b1; cfg_ch = 3'(ch); cfg_mult = 15'(m); cfg_shift = 6'(s); cfg_zp = 8'(z);
    @(posedge sclk); #2;
    cfg_wr = 1'b0;
  endtask

  task automatic cfg_all(input int m, input int s, input int z);
    for (int k = 0; k < CH; k++) cfg(k, m, s, z);
  endtask

  task automatic send_one(input logic signed [DW-1:0] v);
    set_lanes(v);
    data_in_vld = 1'b1;
    @(posedge sclk); #2;
    data_in_vld = 1'b0;
  endtask

  task automatic wait_out(output logic [63:0] o, output int lat);
    lat = 0;
    o   = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge sclk);
      if (data_out_vld) begin
        lat = i;
        o   = data_out;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    s_rst = 1'b1;
    @(posedge sclk); #2;
    s_rst = 1'b0;
  endtask

  logic [63:0] o;
  int          lat;
  logic [15:0] pat = 16'b1011_0001_1100_0110;
  int          got_n, rdy_bad, hold_bad, extra;
  bit          mon_done, acc, held;
  logic [63:0] held_val, exp_v;

  initial begin
    s_rst = 1'b1; data_in = '0; data_in_vld = 1'b0; data_out_rdy = 1'b1;
    cfg_wr = 1'b0; cfg_ch = '0; cfg_mult = '0; cfg_shift = '0; cfg_zp = '0;
    repeat (2) @(posedge sclk); #2;
    check_eq("rst_vld", data_out_vld, 0);
    check_eq("rst_dout", data_out, 0);
    check_eq("rst_rdy", data_in_rdy, 1);
    s_rst = 1'b0;

    // x/2 + 128
    cfg_all(16384, 15, 128);
    send_one(100);  wait_out(o, lat);
    check_eq("lat_basic", lat, 5);
    check_eq("basic_100", o, {8{8'd178}});
    send_one(-101); wait_out(o, lat);
    check_eq("basic_m101", o, {8{EXP_M101}});
    send_one(0);    wait_out(o, lat);
    check_eq("basic_0", o, {8{8'd128}});
    repeat (3) @(negedge sclk);
    check_eq("idle_vld", data_out_vld, 0);
    check_eq("idle_hold", data_out, {8{8'd128}});

    cfg_all(32767, 0, 0);
    send_one(8388607);  wait_out(o, lat);
    check_eq("sat_hi", o, {8{8'hFF}});
    send_one(-8388608); wait_out(o, lat);
    check_eq("sat_lo", o, 64'd0);

    pulse_reset();
    cfg(3, 32767, 15, 0);
    cfg(5, 1, 0, 10);
    cfg(8 + 1, 0, 0, 0);
    send_one(200); wait_out(o, lat);
    check_eq("perch_lat", lat, 5);
    check_eq("perch", o, 64'h0000_D200_C800_0000);

    // identity table for the backpressure stream; lane0 zp changes at beat 10's accept edge
    cfg_all(1, 0, 0);
    got_n = 0; rdy_bad = 0; hold_bad = 0; mon_done = 1'b0; held = 1'b0; held_val = '0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          for (int k = 0; k < CH; k++) data_in[k*DW +: DW] = DW'(i*8 + k);
          data_in_vld = 1'b1;
          acc = 1'b0;
          for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge sclk);
            acc = data_in_rdy;
            if (acc && i == 10) begin
              cfg_wr = 1'b1; cfg_ch = 3'd0; cfg_mult = 15'd1; cfg_shift = 6'd0; cfg_zp = 8'd100;
            end
            @(posedge sclk); #2;
            cfg_wr = 1'b0;
          end
        end
        data_in_vld = 1'b0;
      end
      begin
        for (int c = 0; c < 400 && !mon_done; c++) begin
          data_out_rdy = pat[c%16];
          @(posedge sclk); #2;
        end
        data_out_rdy = 1'b1;
      end
      begin
        for (int c = 0; c < 400 && got_n < 20; c++) begin
          @(negedge sclk);
          if (data_in_rdy !== (!data_out_vld || data_out_rdy)) rdy_bad++;
          if (held && (data_out_vld !== 1'b1 || data_out !== held_val)) hold_bad++;
          held     = data_out_vld && !data_out_rdy;
          held_val = data_out;
          if (data_out_vld && data_out_rdy) begin
            for (int k = 0; k < CH; k++)
              exp_v[k*8 +: 8] = 8'(got_n*8 + k + ((k == 0 && got_n > 10) ? 100 : 0));
            check_eq($sformatf("bp_beat%0d", got_n), data_out, exp_v);
            got_n++;
          end
        end
        mon_done = 1'b1;
      end
    join
    extra = 0;
    repeat (10) begin
      @(negedge sclk);
      if (data_out_vld) extra++;
    end
    check_eq("bp_count", got_n, 20);
    check_eq("bp_extra", extra, 0);
    check_eq("bp_rdy", rdy_bad, 0);
    check_eq("bp_hold", hold_bad, 0);

    // fill pipeline against a stalled sink, then reset with beats in flight
    data_out_rdy = 1'b0;
    set_lanes(500);
    data_in_vld = 1'b1;
    repeat (3) begin
      @(posedge sclk); #2;
    end
    data_in_vld = 1'b0;
    for (int i = 0; i < 10 && !data_out_vld; i++) @(negedge sclk);
    check_eq("rstmid_pre_vld", data_out_vld, 1);
    #1 s_rst = 1'b1;
    #1;
    check_eq("rstmid_vld", data_out_vld, 0);
    check_eq("rstmid_dout", data_out, 0);
    check_eq("rstmid_rdy", data_in_rdy, 1);
    @(posedge sclk); #2;
    s_rst = 1'b0;
    data_out_rdy = 1'b1;
    extra = 0;
    repeat (10) begin
      @(negedge sclk);
      if (data_out_vld) extra++;
    end
    check_eq("rstmid_stale", extra, 0);
    send_one(500); wait_out(o, lat);
    check_eq("rstmid_lat", lat, 5);
    check_eq("rstmid_tbl", o, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
